// File: rtl/central_memory_pkg.sv
// Shared defaults and types for the central memory: width, address map and
// the requestor index type used by the arbiter pointer.
package central_memory_pkg;

  localparam int unsigned WIDTH_DEF     = 32;
  localparam logic [31:0] BASE_DEF      = 32'h30000;
  localparam int unsigned ROM_WORDS_DEF = 32'h4000;
  localparam int unsigned MAX_RD        = 8;

  // Wide enough for MAX_RD read channels plus the write requestor.
  typedef logic [$clog2(MAX_RD+1)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter
  import central_memory_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  ch_idx_t      ptr_q, ptr_d;
  logic [N-1:0] gnt;
  logic         hit;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    hit   = 1'b0;
    // First pass covers indices at/after the pointer, second pass wraps around.
    for (int j = 0; j < N; j++) begin
      if (!hit && req_i[j] && (ch_idx_t'(j) >= ptr_q)) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        ptr_d  = (j == N-1) ? '0 : ch_idx_t'(j+1);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!hit && req_i[j] && (ch_idx_t'(j) < ptr_q)) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        ptr_d  = (j == N-1) ? '0 : ch_idx_t'(j+1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign gnt_o = rst_ni ? gnt : '0;

endmodule

// File: rtl/central_memory_mp.sv
// Multi-port front end for one single-port byte-writable RAM: NUM_RD read
// channels and one write channel share the port through a round-robin arbiter.
module central_memory_mp
  import central_memory_pkg::*;
#(
  parameter int unsigned      WIDTH      = WIDTH_DEF,
  parameter int unsigned      DEPTH_LOG2 = 16,
  parameter int unsigned      NUM_RD     = 3,
  parameter logic [WIDTH-1:0] BASE       = WIDTH'(BASE_DEF),
  parameter int unsigned      ROM_WORDS  = ROM_WORDS_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD-1:0][WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0][WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_err,
  input  logic                         wr_req,
  input  logic [WIDTH-1:0]             wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [WIDTH/8-1:0]           wr_be,
  output logic                         wr_gnt,
  output logic                         wr_err
);

  localparam int unsigned NB   = WIDTH/8;
  localparam int unsigned NREQ = NUM_RD + 1;

  logic [NREQ-1:0] gnt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .req_i  ({wr_req, rd_req}),
    .gnt_o  (gnt)
  );

  assign rd_gnt = gnt[NUM_RD-1:0];
  assign wr_gnt = gnt[NUM_RD];

  logic [WIDTH-1:0]      acc_addr, off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_rng, wr_ok;

  always_comb begin
    acc_addr = wr_addr;
    for (int k = 0; k < NUM_RD; k++)
      if (gnt[k]) acc_addr = rd_addr[k];
  end

  // Once addr >= BASE the subtraction cannot wrap, so range is "no high bits".
  assign off    = acc_addr - BASE;
  assign in_rng = (acc_addr >= BASE) && ((off >> DEPTH_LOG2) == '0);
  assign idx    = off[DEPTH_LOG2-1:0];
  assign wr_ok  = wr_gnt && in_rng && (32'(idx) >= ROM_WORDS);

  // Array is never reset so elaboration-time preload survives reset.
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] ram_q;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    ram_q <= mem[idx];
  end

  logic [NUM_RD-1:0]            vld_q, err_q;
  logic [NUM_RD-1:0][WIDTH-1:0] data_q;
  logic                         wr_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= '0;
      err_q    <= '0;
      data_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      vld_q    <= rd_gnt;
      err_q    <= rd_gnt & {NUM_RD{~in_rng}};
      data_q   <= rd_data;
      wr_err_q <= wr_gnt && (wr_be != '0) && !wr_ok;
    end
  end

  // RAM output is steered to the channel that owns it; others hold.
  always_comb begin
    rd_data = data_q;
    for (int k = 0; k < NUM_RD; k++)
      if (vld_q[k]) rd_data[k] = err_q[k] ? '0 : ram_q;
  end

  assign rd_valid = vld_q;
  assign rd_err   = err_q;
  assign wr_err   = wr_err_q;

endmodule
